// File: rtl/aesl_deadlock_pkg.sv
// Shared types and constants for the dataflow deadlock monitor.
package aesl_deadlock_pkg;

  localparam int unsigned PROC_IDX_W   = 5;
  localparam int unsigned DETECT_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMING  = 2'd1,
    ST_BLOCKED = 2'd2
  } dl_state_e;

  // Saturating increment for the declaration counter.
  function automatic logic [DETECT_CNT_W-1:0] sat_inc(input logic [DETECT_CNT_W-1:0] value);
    if (value == {DETECT_CNT_W{1'b1}}) begin
      return value;
    end else begin
      return value + DETECT_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/aesl_deadlock_axis_map.sv
// Folds per-axis blocked flags onto their owning process slots.
module aesl_deadlock_axis_map
  import aesl_deadlock_pkg::*;
#(
  parameter int                               N_PROC   = 6,
  parameter int                               N_AXIS   = 2,
  parameter logic [N_AXIS*PROC_IDX_W-1:0]     AXIS_MAP = {5'd5, 5'd0}
) (
  input  logic [N_AXIS-1:0] axis_block_sigs,
  output logic [N_PROC-1:0] axis_vec
);

  logic [N_PROC-1:0] axis_vec_s;

  // OR every axis flag into the process it is mapped to; unmapped processes stay 0.
  always_comb begin
    axis_vec_s = {N_PROC{1'b0}};
    for (int p = 0; p < N_PROC; p++) begin
      for (int k = 0; k < N_AXIS; k++) begin
        if (AXIS_MAP[k*PROC_IDX_W +: PROC_IDX_W] == PROC_IDX_W'(p)) begin
          axis_vec_s[p] = axis_vec_s[p] | axis_block_sigs[k];
        end else begin
          axis_vec_s[p] = axis_vec_s[p];
        end
      end
    end
  end

  assign axis_vec = axis_vec_s;

endmodule

// File: rtl/aesl_deadlock_param_monitor.sv
// Declares a deadlock once every process is stopped, with at least one axis
// input blocked, for CONFIRM_CYCLES consecutive cycles.
module aesl_deadlock_param_monitor
  import aesl_deadlock_pkg::*;
#(
  parameter int                           N_PROC         = 6,
  parameter int                           N_AXIS         = 2,
  parameter logic [N_AXIS*PROC_IDX_W-1:0] AXIS_MAP       = {5'd5, 5'd0},
  parameter int                           CONFIRM_CYCLES = 4,
  parameter bit                           STICKY         = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_AXIS-1:0]       axis_block_sigs,
  input  logic [N_PROC-1:0]       inst_idle_sigs,
  input  logic [N_PROC-1:0]       inst_block_sigs,
  input  logic                    clear,
  output logic                    block,
  output logic                    block_pulse,
  output logic [N_PROC-1:0]       blocked_proc_vec,
  output logic [DETECT_CNT_W-1:0] detect_count
);

  localparam int                 CNT_W     = $clog2(CONFIRM_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CONFIRM_C = CNT_W'(CONFIRM_CYCLES);

  logic [N_PROC-1:0]       axis_vec_s;
  logic [N_PROC-1:0]       stop_s;
  logic                    cand_s;
  logic                    enter_s;
  logic [CNT_W-1:0]        cnt_inc_s;
  logic [CNT_W-1:0]        cnt_nxt_s;
  dl_state_e               state_nxt_s;
  dl_state_e               state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    block_r;
  logic                    pulse_r;
  logic [N_PROC-1:0]       vec_r;
  logic [DETECT_CNT_W-1:0] detect_r;

  aesl_deadlock_axis_map #(
    .N_PROC   (N_PROC),
    .N_AXIS   (N_AXIS),
    .AXIS_MAP (AXIS_MAP)
  ) u_axis_map (
    .axis_block_sigs (axis_block_sigs),
    .axis_vec        (axis_vec_s)
  );

  assign stop_s    = inst_idle_sigs | inst_block_sigs | axis_vec_s;
  assign cand_s    = (|axis_vec_s) & (&stop_s);
  assign cnt_inc_s = cnt_r + CNT_W'(1);
  assign enter_s   = (state_nxt_s == ST_BLOCKED) && (state_r != ST_BLOCKED);

  // Next-state and stall-counter logic; clear outranks cand in every state.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (clear || !cand_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (CONFIRM_CYCLES == 1) begin
          state_nxt_s = ST_BLOCKED;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_ARMING;
          cnt_nxt_s   = CNT_W'(1);
        end
      end
      ST_ARMING: begin
        if (clear || !cand_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (cnt_inc_s == CONFIRM_C) begin
          state_nxt_s = ST_BLOCKED;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_ARMING;
          cnt_nxt_s   = cnt_inc_s;
        end
      end
      ST_BLOCKED: begin
        cnt_nxt_s = {CNT_W{1'b0}};
        if (clear || (!STICKY && !cand_s)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BLOCKED;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and registered outputs; the snapshot is taken only on entry to BLOCKED.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      block_r  <= 1'b0;
      pulse_r  <= 1'b0;
      vec_r    <= {N_PROC{1'b0}};
      detect_r <= {DETECT_CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      block_r <= (state_nxt_s == ST_BLOCKED);
      pulse_r <= enter_s;
      if (enter_s) begin
        vec_r    <= inst_block_sigs | axis_vec_s;
        detect_r <= sat_inc(detect_r);
      end
    end
  end

  assign block            = block_r;
  assign block_pulse      = pulse_r;
  assign blocked_proc_vec = vec_r;
  assign detect_count     = detect_r;

endmodule

// File: tb/tb_aesl_deadlock_param_monitor.sv
// Table-driven scoreboard bench: instance A uses defaults, instance B is non-sticky with a one-cycle confirm.
module tb_aesl_deadlock_param_monitor;

  logic       clock;
  logic       reset;
  logic [1:0] axis_block_sigs;
  logic [5:0] inst_idle_sigs;
  logic [5:0] inst_block_sigs;
  logic       clear;

  logic       a_block, a_pulse, b_block, b_pulse;
  logic [5:0] a_vec, b_vec;
  logic [7:0] a_cnt, b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  aesl_deadlock_param_monitor dut_a (
    .clock            (clock),
    .reset            (reset),
    .axis_block_sigs  (axis_block_sigs),
    .inst_idle_sigs   (inst_idle_sigs),
    .inst_block_sigs  (inst_block_sigs),
    .clear            (clear),
    .block            (a_block),
    .block_pulse      (a_pulse),
    .blocked_proc_vec (a_vec),
    .detect_count     (a_cnt)
  );

  aesl_deadlock_param_monitor #(
    .CONFIRM_CYCLES (1),
    .STICKY         (1'b0)
  ) dut_b (
    .clock            (clock),
    .reset            (reset),
    .axis_block_sigs  (axis_block_sigs),
    .inst_idle_sigs   (inst_idle_sigs),
    .inst_block_sigs  (inst_block_sigs),
    .clear            (clear),
    .block            (b_block),
    .block_pulse      (b_pulse),
    .blocked_proc_vec (b_vec),
    .detect_count     (b_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       rst;
    logic       clr;
    logic [1:0] ax;
    logic [5:0] id;
    logic [5:0] bk;
    logic       eb;
    logic       ep;
    logic [5:0] ev;
    logic [7:0] ec;
    string      nm;
  } vec_t;

  typedef struct {
    logic       a_b, a_p, b_b, b_p;
    logic [5:0] a_v, b_v;
    logic [7:0] a_c, b_c;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[27];

  // Model state for instance B: block is cand delayed one cycle.
  logic       mb_blk = 1'b0;
  logic       mb_pulse = 1'b0;
  logic [5:0] mb_vec = 6'd0;
  logic [7:0] mb_cnt = 8'd0;

  function automatic vec_t row(input logic r, input logic c, input logic [1:0] ax,
                               input logic [5:0] id, input logic [5:0] bk, input logic eb,
                               input logic ep, input logic [5:0] ev, input logic [7:0] ec,
                               input string nm);
    vec_t v;
    v.rst = r; v.clr = c; v.ax = ax; v.id = id; v.bk = bk;
    v.eb = eb; v.ep = ep; v.ev = ev; v.ec = ec; v.nm = nm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic [1:0] ax, input logic [5:0] id,
                      input logic [5:0] bk, input logic eb, input logic ep, input logic [5:0] ev,
                      input logic [7:0] ec, input string nm);
    exp_t       e;
    exp_t       got;
    logic [5:0] av;
    logic       cand;
    logic       nb;
    @(negedge clock);
    reset = r; clear = c; axis_block_sigs = ax; inst_idle_sigs = id; inst_block_sigs = bk;
    av   = {ax[1], 4'b0000, ax[0]};
    cand = (|av) & (&(id | bk | av));
    if (r) begin
      mb_blk = 1'b0; mb_pulse = 1'b0; mb_vec = 6'd0; mb_cnt = 8'd0;
    end else begin
      nb       = cand & ~c;
      mb_pulse = nb & ~mb_blk;
      if (mb_pulse) begin
        mb_vec = bk | av;
        if (mb_cnt != 8'd255) mb_cnt = mb_cnt + 8'd1;
      end
      mb_blk = nb;
    end
    e.a_b = eb; e.a_p = ep; e.a_v = ev; e.a_c = ec;
    e.b_b = mb_blk; e.b_p = mb_pulse; e.b_v = mb_vec; e.b_c = mb_cnt; e.nm = nm;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    got = exp_q.pop_front();
    chk({got.nm, ".a_block"}, {7'd0, a_block}, {7'd0, got.a_b});
    chk({got.nm, ".a_pulse"}, {7'd0, a_pulse}, {7'd0, got.a_p});
    chk({got.nm, ".a_vec"},   {2'd0, a_vec},   {2'd0, got.a_v});
    chk({got.nm, ".a_count"}, a_cnt,           got.a_c);
    chk({got.nm, ".b_block"}, {7'd0, b_block}, {7'd0, got.b_b});
    chk({got.nm, ".b_pulse"}, {7'd0, b_pulse}, {7'd0, got.b_p});
    chk({got.nm, ".b_vec"},   {2'd0, b_vec},   {2'd0, got.b_v});
    chk({got.nm, ".b_count"}, b_cnt,           got.b_c);
  endtask

  initial begin
    logic [7:0] ecnt;
    logic [5:0] evec;
    reset = 1'b1; clear = 1'b0; axis_block_sigs = 2'b00;
    inst_idle_sigs = 6'h00; inst_block_sigs = 6'h00;

    tbl[0]  = row(1'b1, 1'b0, 2'b00, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h00, 8'd0, "reset");
    tbl[1]  = row(1'b0, 1'b0, 2'b01, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h00, 8'd0, "arm1");
    tbl[2]  = row(1'b0, 1'b0, 2'b01, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h00, 8'd0, "arm2");
    tbl[3]  = row(1'b0, 1'b0, 2'b01, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h00, 8'd0, "arm3");
    tbl[4]  = row(1'b0, 1'b0, 2'b01, 6'h3F, 6'h00, 1'b1, 1'b1, 6'h01, 8'd1, "declare");
    tbl[5]  = row(1'b0, 1'b0, 2'b00, 6'h3F, 6'h00, 1'b1, 1'b0, 6'h01, 8'd1, "sticky_hold");
    tbl[6]  = row(1'b0, 1'b1, 2'b00, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h01, 8'd1, "clear");
    tbl[7]  = row(1'b0, 1'b1, 2'b01, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h01, 8'd1, "clear_over_cand");
    tbl[8]  = row(1'b0, 1'b0, 2'b01, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h01, 8'd1, "rearm1");
    tbl[9]  = row(1'b0, 1'b0, 2'b01, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h01, 8'd1, "rearm2");
    tbl[10] = row(1'b0, 1'b0, 2'b01, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h01, 8'd1, "rearm3");
    tbl[11] = row(1'b0, 1'b0, 2'b01, 6'h3B, 6'h00, 1'b0, 1'b0, 6'h01, 8'd1, "break");
    tbl[12] = row(1'b0, 1'b0, 2'b01, 6'h3B, 6'h04, 1'b0, 1'b0, 6'h01, 8'd1, "fresh1");
    tbl[13] = row(1'b0, 1'b0, 2'b01, 6'h3B, 6'h04, 1'b0, 1'b0, 6'h01, 8'd1, "fresh2");
    tbl[14] = row(1'b0, 1'b0, 2'b01, 6'h3B, 6'h04, 1'b0, 1'b0, 6'h01, 8'd1, "fresh3");
    tbl[15] = row(1'b0, 1'b0, 2'b01, 6'h3B, 6'h04, 1'b1, 1'b1, 6'h05, 8'd2, "redeclare");
    tbl[16] = row(1'b0, 1'b1, 2'b00, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h05, 8'd2, "clear2");
    tbl[17] = row(1'b0, 1'b0, 2'b10, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h05, 8'd2, "axis5_arm1");
    tbl[18] = row(1'b0, 1'b0, 2'b10, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h05, 8'd2, "axis5_arm2");
    tbl[19] = row(1'b0, 1'b0, 2'b10, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h05, 8'd2, "axis5_arm3");
    tbl[20] = row(1'b0, 1'b0, 2'b10, 6'h3F, 6'h00, 1'b1, 1'b1, 6'h20, 8'd3, "axis5_declare");
    tbl[21] = row(1'b1, 1'b0, 2'b10, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h00, 8'd0, "reset_blocked");
    tbl[22] = row(1'b0, 1'b0, 2'b01, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h00, 8'd0, "arm_again1");
    tbl[23] = row(1'b0, 1'b0, 2'b01, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h00, 8'd0, "arm_again2");
    tbl[24] = row(1'b0, 1'b0, 2'b01, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h00, 8'd0, "arm_again3");
    tbl[25] = row(1'b1, 1'b0, 2'b01, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h00, 8'd0, "reset_arming");
    tbl[26] = row(1'b0, 1'b0, 2'b01, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h00, 8'd0, "post_reset_arm1");

    for (int i = 0; i < 27; i++) begin
      step(tbl[i].rst, tbl[i].clr, tbl[i].ax, tbl[i].id, tbl[i].bk,
           tbl[i].eb, tbl[i].ep, tbl[i].ev, tbl[i].ec, tbl[i].nm);
    end

    // All idle but no axis blocked: never a deadlock.
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b0, 2'b00, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h00, 8'd0, "no_axis");
    end

    // 300 declarations: counter saturates at 255.
    step(1'b1, 1'b0, 2'b00, 6'h3F, 6'h00, 1'b0, 1'b0, 6'h00, 8'd0, "sat_reset");
    ecnt = 8'd0;
    evec = 6'h00;
    for (int n = 1; n <= 300; n++) begin
      for (int j = 0; j < 3; j++) begin
        step(1'b0, 1'b0, 2'b01, 6'h3F, 6'h00, 1'b0, 1'b0, evec, ecnt, "sat_arm");
      end
      if (ecnt != 8'd255) ecnt = ecnt + 8'd1;
      evec = 6'h01;
      step(1'b0, 1'b0, 2'b01, 6'h3F, 6'h00, 1'b1, 1'b1, evec, ecnt, "sat_declare");
      step(1'b0, 1'b1, 2'b00, 6'h3F, 6'h00, 1'b0, 1'b0, evec, ecnt, "sat_clear");
    end
    chk("sat_final", a_cnt, 8'd255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
